// File: rtl/dc_ipu_scaler_coord_seq.sv
// Raster-order source-coordinate sequencer for the scaler filter stage; clamp option: DC_IPU_COORD_CLAMP_EN.
// Latency: first pixel one cycle after start, then 1 pixel/clk; all out_* held while out_valid & !out_ready.
module dc_ipu_scaler_coord_seq #(
    parameter int COEFF_WIDTH = 4,
    parameter int COORD_WIDTH = 12
) (
    input  logic                               clk,
    input  logic                               nreset,
    input  logic                               clr,
    input  logic                               start,
    input  logic [COORD_WIDTH-1:0]             cfg_src_w,
    input  logic [COORD_WIDTH-1:0]             cfg_src_h,
    input  logic [COORD_WIDTH-1:0]             cfg_dst_w,
    input  logic [COORD_WIDTH-1:0]             cfg_dst_h,
    input  logic [COORD_WIDTH+COEFF_WIDTH-1:0] cfg_step_x,
    input  logic [COORD_WIDTH+COEFF_WIDTH-1:0] cfg_step_y,
    output logic                               busy,
    output logic                               done,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COORD_WIDTH-1:0]             out_src_x,
    output logic [COORD_WIDTH-1:0]             out_src_y,
    output logic [COEFF_WIDTH-1:0]             out_coeff_x,
    output logic [COEFF_WIDTH-1:0]             out_coeff_y,
    output logic                               out_eol,
    output logic                               out_eof
);
    localparam int AW = COORD_WIDTH + COEFF_WIDTH;
    localparam logic [COORD_WIDTH-1:0] ONE = COORD_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state_q, state_d;

    logic [COORD_WIDTH-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [COORD_WIDTH-1:0] dx_q, dy_q;
    logic [AW-1:0]          step_x_q, step_y_q, acc_x_q, acc_y_q;

    logic xfer, start_acc, line_end;
    assign xfer      = out_valid & out_ready;
    assign start_acc = start & ~clr & (state_q == IDLE);
    assign line_end  = (dx_q == dst_w_q - ONE);
    assign busy      = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (xfer && out_eof) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    // Position of the pixel to present next: frame origin on start, else the successor of the current one.
    logic [COORD_WIDTH-1:0] ld_dx, ld_dy, ld_dst_w, ld_dst_h;
    logic [AW-1:0]          ld_acc_x, ld_acc_y;

    always_comb begin
        ld_dx    = dx_q;
        ld_dy    = dy_q;
        ld_acc_x = acc_x_q;
        ld_acc_y = acc_y_q;
        ld_dst_w = dst_w_q;
        ld_dst_h = dst_h_q;
        if (start_acc) begin
            ld_dx    = '0;
            ld_dy    = '0;
            ld_acc_x = '0;
            ld_acc_y = '0;
            ld_dst_w = cfg_dst_w;
            ld_dst_h = cfg_dst_h;
        end else if (line_end) begin
            ld_dx    = '0;
            ld_acc_x = '0;
            ld_dy    = dy_q + ONE;
            ld_acc_y = acc_y_q + step_y_q;
        end else begin
            ld_dx    = dx_q + ONE;
            ld_acc_x = acc_x_q + step_x_q;
        end
    end

`ifdef DC_IPU_COORD_CLAMP_EN
    logic [COORD_WIDTH-1:0] ld_src_w, ld_src_h;
    assign ld_src_w = start_acc ? cfg_src_w : src_w_q;
    assign ld_src_h = start_acc ? cfg_src_h : src_h_q;
`else
    logic unused_src;
    assign unused_src = ^{src_w_q, src_h_q};
`endif

    logic [COORD_WIDTH-1:0] fmt_x, fmt_y;
    logic [COEFF_WIDTH-1:0] fmt_cx, fmt_cy;
    logic                   fmt_eol, fmt_eof;

    always_comb begin
        fmt_x   = ld_acc_x[AW-1:COEFF_WIDTH];
        fmt_y   = ld_acc_y[AW-1:COEFF_WIDTH];
        fmt_cx  = ld_acc_x[COEFF_WIDTH-1:0];
        fmt_cy  = ld_acc_y[COEFF_WIDTH-1:0];
        fmt_eol = (ld_dx == ld_dst_w - ONE);
        fmt_eof = fmt_eol & (ld_dy == ld_dst_h - ONE);
`ifdef DC_IPU_COORD_CLAMP_EN
        // Clamp only the presented value so the 2x2 neighbourhood stays inside the image.
        if (fmt_x >= ld_src_w - ONE) begin
            fmt_x  = ld_src_w - ONE;
            fmt_cx = '0;
        end
        if (fmt_y >= ld_src_h - ONE) begin
            fmt_y  = ld_src_h - ONE;
            fmt_cy = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            src_w_q     <= '0;
            src_h_q     <= '0;
            dst_w_q     <= '0;
            dst_h_q     <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_src_x   <= '0;
            out_src_y   <= '0;
            out_coeff_x <= '0;
            out_coeff_y <= '0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                acc_x_q     <= '0;
                acc_y_q     <= '0;
                dx_q        <= '0;
                dy_q        <= '0;
                done        <= 1'b0;
                out_valid   <= 1'b0;
                out_src_x   <= '0;
                out_src_y   <= '0;
                out_coeff_x <= '0;
                out_coeff_y <= '0;
                out_eol     <= 1'b0;
                out_eof     <= 1'b0;
            end else begin
                done <= xfer & out_eof;
                if (start_acc || (xfer && !out_eof)) begin
                    acc_x_q     <= ld_acc_x;
                    acc_y_q     <= ld_acc_y;
                    dx_q        <= ld_dx;
                    dy_q        <= ld_dy;
                    out_valid   <= 1'b1;
                    out_src_x   <= fmt_x;
                    out_src_y   <= fmt_y;
                    out_coeff_x <= fmt_cx;
                    out_coeff_y <= fmt_cy;
                    out_eol     <= fmt_eol;
                    out_eof     <= fmt_eof;
                end else if (xfer) begin
                    out_valid <= 1'b0;
                end
                if (start_acc) begin
                    src_w_q  <= cfg_src_w;
                    src_h_q  <= cfg_src_h;
                    dst_w_q  <= cfg_dst_w;
                    dst_h_q  <= cfg_dst_h;
                    step_x_q <= cfg_step_x;
                    step_y_q <= cfg_step_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_dc_ipu_scaler_coord_seq.sv
// Directed bench for dc_ipu_scaler_coord_seq: a frame-level model predicts every presented pixel,
// plus literal expectations for the reference frames.
module tb_dc_ipu_scaler_coord_seq;
    localparam int CW = 4;
    localparam int XW = 12;
    localparam int AW = XW + CW;
`ifdef DC_IPU_COORD_CLAMP_EN
    localparam int CLAMP = 1;
`else
    localparam int CLAMP = 0;
`endif

    logic clk = 1'b0;
    logic nreset, clr, start, out_ready;
    logic [XW-1:0] cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h;
    logic [AW-1:0] cfg_step_x, cfg_step_y;
    logic busy, done, out_valid, out_eol, out_eof;
    logic [XW-1:0] out_src_x, out_src_y;
    logic [CW-1:0] out_coeff_x, out_coeff_y;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [CW-1:0] cx;
        logic [XW-1:0] y;
        logic [CW-1:0] cy;
        logic          eol;
        logic          eof;
    } pix_t;

    int   checks = 0;
    int   failures = 0;
    int   xfer_cnt = 0;
    int   busy_cyc = 0;
    logic model_run = 1'b0;
    logic model_done = 1'b0;
    logic ready_toggle = 1'b0;
    pix_t exp_q[$];
    pix_t log_q[$];
    pix_t t1[8];

    always #5 clk = ~clk;

    dc_ipu_scaler_coord_seq #(.COEFF_WIDTH(CW), .COORD_WIDTH(XW)) dut (
        .clk(clk), .nreset(nreset), .clr(clr), .start(start),
        .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
        .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
        .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_src_x(out_src_x), .out_src_y(out_src_y),
        .out_coeff_x(out_coeff_x), .out_coeff_y(out_coeff_y),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic pix_t mk(input int x, input int cx, input int y, input int cy,
                                input int eol, input int eof);
        pix_t p;
        p.x   = XW'(x);
        p.cx  = CW'(cx);
        p.y   = XW'(y);
        p.cy  = CW'(cy);
        p.eol = (eol != 0);
        p.eof = (eof != 0);
        return p;
    endfunction

    // Source position of output pixel (x,y) is simply x*step_x, y*step_y in fixed point.
    task automatic build_frame(input int sw, input int sh, input int dw, input int dh,
                               input int stx, input int sty);
        logic [31:0] ax, ay;
        pix_t p;
        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                ax = 32'(x * stx);
                ay = 32'(y * sty);
                p.x   = ax[AW-1:CW];
                p.cx  = ax[CW-1:0];
                p.y   = ay[AW-1:CW];
                p.cy  = ay[CW-1:0];
                p.eol = (x == dw - 1);
                p.eof = (x == dw - 1) && (y == dh - 1);
                if (CLAMP != 0 && int'(p.x) >= sw - 1) begin
                    p.x  = XW'(sw - 1);
                    p.cx = '0;
                end
                if (CLAMP != 0 && int'(p.y) >= sh - 1) begin
                    p.y  = XW'(sh - 1);
                    p.cy = '0;
                end
                exp_q.push_back(p);
            end
        end
    endtask

    // Per-cycle compare against the frame model; inputs change only at posedge+1.
    initial begin
        pix_t cur, p;
        logic nxt_done;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                chk("reset_outputs", {busy, done, out_valid, out_src_x, out_src_y,
                                      out_coeff_x, out_coeff_y, out_eol, out_eof}, 64'd0);
                model_run  = 1'b0;
                model_done = 1'b0;
                exp_q.delete();
                continue;
            end
            cur.x   = out_src_x;
            cur.cx  = out_coeff_x;
            cur.y   = out_src_y;
            cur.cy  = out_coeff_y;
            cur.eol = out_eol;
            cur.eof = out_eof;
            chk("busy", busy, model_run);
            chk("out_valid", out_valid, model_run);
            chk("done", done, model_done);
            if (busy) busy_cyc++;
            if (model_run) begin
                if (exp_q.size() == 0) chk("model_queue_empty", 1, 0);
                else chk("pixel", 64'(cur), 64'(exp_q[0]));
            end
            nxt_done = 1'b0;
            if (clr) begin
                model_run = 1'b0;
                exp_q.delete();
            end else if (model_run && out_ready) begin
                log_q.push_back(cur);
                xfer_cnt++;
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    if (p.eof) begin
                        model_run = 1'b0;
                        nxt_done  = 1'b1;
                    end
                end
            end else if (!model_run && start) begin
                build_frame(int'(cfg_src_w), int'(cfg_src_h), int'(cfg_dst_w), int'(cfg_dst_h),
                            int'(cfg_step_x), int'(cfg_step_y));
                model_run = 1'b1;
            end
            model_done = nxt_done;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) out_ready = ~out_ready;
        end
    end

    task automatic do_start(input int sw, input int sh, input int dw, input int dh,
                            input int stx, input int sty);
        cfg_src_w  = XW'(sw);
        cfg_src_h  = XW'(sh);
        cfg_dst_w  = XW'(dw);
        cfg_dst_h  = XW'(dh);
        cfg_step_x = AW'(stx);
        cfg_step_y = AW'(sty);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n;
        for (n = 0; n < bound; n++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk(name, done, 1);
    endtask

    task automatic check_t1_log(input string name);
        chk({name, "_count"}, log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk($sformatf("%s_pix%0d", name, i), 64'(log_q[i]), 64'(t1[i]));
    endtask

    initial begin
        t1[0] = mk(0, 0, 0, 0, 0, 0);
        t1[1] = mk(0, 8, 0, 0, 0, 0);
        t1[2] = mk(1, 0, 0, 0, 0, 0);
        t1[3] = mk(1, (CLAMP != 0) ? 0 : 8, 0, 0, 1, 0);
        t1[4] = mk(0, 0, 0, 8, 0, 0);
        t1[5] = mk(0, 8, 0, 8, 0, 0);
        t1[6] = mk(1, 0, 0, 8, 0, 0);
        t1[7] = mk(1, (CLAMP != 0) ? 0 : 8, 0, 8, 1, 1);

        nreset = 1'b0; clr = 1'b0; start = 1'b0; out_ready = 1'b1;
        cfg_src_w = '0; cfg_src_h = '0; cfg_dst_w = '0; cfg_dst_h = '0;
        cfg_step_x = '0; cfg_step_y = '0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: 2x2 -> 4x2 at half-texel steps, no backpressure
        log_q.delete();
        do_start(2, 2, 4, 2, 8, 8);
        wait_done(50, "t1_done");
        check_t1_log("t1");

        // T2: same frame with alternating ready
        log_q.delete();
        xfer_cnt = 0;
        out_ready = 1'b0;
        ready_toggle = 1'b1;
        do_start(2, 2, 4, 2, 8, 8);
        wait_done(100, "t2_done");
        ready_toggle = 1'b0;
        out_ready = 1'b1;
        chk("t2_transfers", xfer_cnt, 8);
        check_t1_log("t2");

        // T3: right-edge behaviour, 2x1 -> 4x1
        log_q.delete();
        do_start(2, 1, 4, 1, 8, 0);
        wait_done(50, "t3_done");
        chk("t3_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t3_pix2", 64'(log_q[2]), 64'(mk(1, 0, 0, 0, 0, 0)));
            chk("t3_pix3", 64'(log_q[3]), 64'(mk(1, (CLAMP != 0) ? 0 : 8, 0, 0, 1, 1)));
        end

        // T4: single-pixel frame, then a back-to-back start on the done cycle
        log_q.delete();
        repeat (2) @(posedge clk);
        #1;
        busy_cyc = 0;
        do_start(1, 1, 1, 1, 16, 16);
        wait_done(20, "t4_done");
        chk("t4_busy_cycles", busy_cyc, 1);
        chk("t4_count", log_q.size(), 1);
        if (log_q.size() >= 1) chk("t4_pix", 64'(log_q[0]), 64'(mk(0, 0, 0, 0, 1, 1)));
        log_q.delete();
        do_start(2, 2, 4, 2, 8, 8);
        wait_done(50, "b2b_done");
        check_t1_log("b2b");

        // T5: clear while pixel 5 is presented, then restart
        log_q.delete();
        xfer_cnt = 0;
        do_start(2, 2, 4, 2, 8, 8);
        for (int n = 0; n < 50 && xfer_cnt != 5; n++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_reach_pix5", xfer_cnt, 5);
        chk("t5_pix5_presented", 64'({out_src_x, out_coeff_x, out_src_y, out_coeff_y}),
            64'({12'd0, 4'd8, 12'd0, 4'd8}));
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("t5_after_clr", {out_valid, busy, done}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        log_q.delete();
        do_start(2, 2, 4, 2, 8, 8);
        wait_done(50, "t5_restart_done");
        check_t1_log("t5_restart");

        // T6: asynchronous reset mid-frame
        do_start(2, 2, 4, 2, 8, 8);
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("t6_async_reset", {busy, done, out_valid, out_src_x, out_src_y,
                               out_coeff_x, out_coeff_y, out_eol, out_eof}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_after_reset", {out_valid, busy}, 2'b00);
        log_q.delete();
        do_start(2, 2, 4, 2, 8, 8);
        wait_done(50, "t6_resume_done");
        check_t1_log("t6_resume");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
